// File: rtl/sync_fifo_core_pkg.sv
// Shared defaults and helpers for the single-clock FIFO slice.
// Holds default geometry, derived pointer/count widths and the entry word type.
// Imported by the interface, the storage sub-module and the FIFO top.
package sync_fifo_core_pkg;

  localparam int unsigned FIFO_DEPTH      = 8;
  localparam int unsigned FIFO_DATA_WIDTH = 8;
  localparam int unsigned PTR_W           = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W           = PTR_W + 1;

  typedef logic [FIFO_DATA_WIDTH-1:0] entry_t;

  // True when v is a non-zero power of two.
  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/sync_fifo_core_if.sv
// Driver/responder bundle for the FIFO: push/pop requests, pop data, status flags.
// No logic of its own; purely wiring between driver and responder.
// Driver owns w_en/r_en/data_in/err_clr; responder owns everything else.
interface sync_fifo_core_if
  import sync_fifo_core_pkg::*;
#(
  parameter int DEPTH      = FIFO_DEPTH,
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic                  w_en;
  logic                  r_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  err_clr;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [CW-1:0]         count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output w_en, r_en, data_in, err_clr,
    input  data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  w_en, r_en, data_in, err_clr,
    output data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

endinterface

// File: rtl/sync_fifo_core_ram.sv
// FIFO storage: DEPTH x DATA_WIDTH, one write port, one registered read port.
// Latency: read data appears the cycle after re; holds its value otherwise.
// No backpressure; the caller guarantees legal addresses and enables.
module sync_fifo_core_ram #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we_i,
  input  logic [ADDR_W-1:0]     waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_W-1:0]     raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Array write; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Registered read port, cleared by reset so pop data starts at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo_core.sv
// Single-clock FIFO responder with occupancy count, almost flags and sticky error flags.
// Latency: pop data and all flags are registered, valid the cycle after the accepting edge.
// Push while full is dropped (overflow), pop while empty is dropped (underflow).
module sync_fifo_core
  import sync_fifo_core_pkg::*;
#(
  parameter int DEPTH      = FIFO_DEPTH,
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int AF_LEVEL   = 6,
  parameter int AE_LEVEL   = 2
) (
  input logic             clk,
  input logic             rst_n,
  sync_fifo_core_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = AW + 1;

  // Parameter sanity, reported at elaboration.
  if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
    $error("sync_fifo_core: DEPTH must be a power of two >= 2");
  end
  if (AF_LEVEL > DEPTH) begin : g_bad_af
    $error("sync_fifo_core: AF_LEVEL must not exceed DEPTH");
  end
  if (AE_LEVEL >= AF_LEVEL) begin : g_bad_ae
    $error("sync_fifo_core: AE_LEVEL must be below AF_LEVEL");
  end

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          af_q, af_d;
  logic          ae_q, ae_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          push_ok;
  logic          pop_ok;

  // Acceptance uses the registered (pre-edge) flags, so full+push+pop pops only
  // and empty+push+pop pushes only; there is no fall-through path.
  assign push_ok = bus.w_en & ~full_q;
  assign pop_ok  = bus.r_en & ~empty_q;

  // Next-state pointers, count, flags derived from the next count, and sticky errors.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push_ok);
    rd_ptr_d = rd_ptr_q + PW'(pop_ok);
    count_d  = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
    af_d    = (count_d >= CW'(AF_LEVEL));
    ae_d    = (count_d <= CW'(AE_LEVEL));
    // A rejected request in the same cycle as err_clr keeps the flag set.
    ovf_d = ovf_q;
    if (bus.err_clr)            ovf_d = 1'b0;
    if (bus.w_en && full_q)     ovf_d = 1'b1;
    unf_d = unf_q;
    if (bus.err_clr)            unf_d = 1'b0;
    if (bus.r_en && empty_q)    unf_d = 1'b1;
  end

  // State registers; reset returns every visible output to its idle value at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  sync_fifo_core_ram #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_W     (AW)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (push_ok),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (bus.data_in),
    .re_i    (pop_ok),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (bus.data_out)
  );

  assign bus.count        = count_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;

endmodule
